// File: rtl/spi_pkg.sv
//==============================================================================
// Module      : spi_pkg
// Description : Shared FSM encoding, SPI mode constants and length clamp helper
//               for the SPI master shift engine.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } spi_state_t;

    // Encoded as {cpol, cpha}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    function automatic int unsigned spi_eff_len(input int unsigned len,
                                                input int unsigned max_len);
        return ((len == 0) || (len > max_len)) ? max_len : len;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_shift_engine_clk_gen.sv
//==============================================================================
// Module      : spi_clk_gen
// Description : Half-period strobe generator; pulses one cycle every
//               clk_div+1 enabled cycles, restarted by load.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module spi_clk_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] clk_div,
    input  logic             enable,
    input  logic             load,
    output logic             half_tick
);

    logic [DIV_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= clk_div;
        end else if (enable) begin
            r_cnt <= (r_cnt == '0) ? clk_div : (r_cnt - DIV_W'(1));
        end
    end

    assign half_tick = enable & ~load & (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/spi_shift_engine.sv
//==============================================================================
// Module      : spi_shift_engine
// Description : Full-duplex SPI master shift engine with runtime length, mode
//               and bit order; start/busy/done host handshake.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module spi_shift_engine
    import spi_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DIV_W  = 8,
    localparam int LEN_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [DIV_W-1:0]  clk_div,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sck,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n
);

    localparam int               EDGE_W     = LEN_W + 1;
    localparam logic [LEN_W-1:0] c_full_len = LEN_W'(DATA_W);

    spi_state_t         r_state;
    logic [LEN_W-1:0]   r_len;
    logic [DATA_W-1:0]  r_tx;
    logic [DATA_W-1:0]  r_rx;
    logic [1:0]         r_mode;
    logic               r_lsb;
    logic [DIV_W-1:0]   r_div;
    logic [EDGE_W-1:0]  r_edge;

    logic               w_accept;
    logic               w_tick;
    logic [LEN_W-1:0]   w_len_eff;
    logic [DATA_W-1:0]  w_aligned;
    logic [DATA_W-1:0]  w_aligned_adv;
    logic               w_first;
    logic               w_head;
    logic [DATA_W-1:0]  w_tx_adv;
    logic [DATA_W-1:0]  w_rx_in;
    logic [EDGE_W-1:0]  w_edge_k;
    logic               w_leading;
    logic               w_last;
    logic               w_cpha1;
    logic               w_cpol1;
    logic [DIV_W-1:0]   w_div_sel;

    assign w_accept  = start & ~busy;
    assign w_len_eff = LEN_W'(spi_eff_len(32'(len), 32'(DATA_W)));

    // MSB-first words are left-justified so the next bit is always the top bit
    assign w_aligned     = lsb_first ? tx_data : (tx_data << (c_full_len - w_len_eff));
    assign w_aligned_adv = lsb_first ? (w_aligned >> 1) : (w_aligned << 1);
    assign w_first       = lsb_first ? tx_data[0] : w_aligned[DATA_W-1];

    assign w_head    = r_lsb ? r_tx[0] : r_tx[DATA_W-1];
    assign w_tx_adv  = r_lsb ? (r_tx >> 1) : (r_tx << 1);
    assign w_rx_in   = r_lsb ? {miso, r_rx[DATA_W-1:1]} : {r_rx[DATA_W-2:0], miso};

    assign w_edge_k  = r_edge + EDGE_W'(1);
    assign w_leading = w_edge_k[0];
    assign w_last    = (w_edge_k == {r_len, 1'b0});
    assign w_cpha1   = (r_mode == SPI_MODE1) || (r_mode == SPI_MODE3);
    assign w_cpol1   = (r_mode == SPI_MODE2) || (r_mode == SPI_MODE3);

    // Every state change coincides with a tick, which reloads the divider itself
    assign w_div_sel = w_accept ? clk_div : r_div;

    spi_clk_gen #(
        .DIV_W (DIV_W)
    ) u_clk_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .clk_div   (w_div_sel),
        .enable    (busy),
        .load      (w_accept),
        .half_tick (w_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_len   <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_mode  <= SPI_MODE0;
            r_lsb   <= 1'b0;
            r_div   <= '0;
            r_edge  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_data <= '0;
            sck     <= 1'b0;
            mosi    <= 1'b0;
            cs_n    <= 1'b1;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                    cs_n    <= 1'b1;
                    mosi    <= 1'b0;
                    sck     <= cpol;
                    if (w_accept) begin
                        r_state <= ST_SETUP;
                        busy    <= 1'b1;
                        cs_n    <= 1'b0;
                        r_len   <= w_len_eff;
                        r_mode  <= {cpol, cpha};
                        r_lsb   <= lsb_first;
                        r_div   <= clk_div;
                        r_edge  <= '0;
                        r_rx    <= '0;
                        r_tx    <= cpha ? w_aligned : w_aligned_adv;
                        mosi    <= cpha ? 1'b0 : w_first;
                    end
                end
                ST_SETUP: begin
                    if (w_tick) begin
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_tick) begin
                        sck    <= ~sck;
                        r_edge <= w_edge_k;
                        // Drive edge is trailing for cpha=0, leading for cpha=1
                        if (w_leading == w_cpha1) begin
                            if (!w_last) begin
                                mosi <= w_head;
                                r_tx <= w_tx_adv;
                            end
                        end else begin
                            r_rx <= w_rx_in;
                        end
                        if (w_last) begin
                            r_state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    sck <= w_cpol1;
                    if (w_tick) begin
                        r_state <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        cs_n    <= 1'b1;
                        mosi    <= 1'b0;
                        rx_data <= r_lsb ? (r_rx >> (c_full_len - r_len)) : r_rx;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_shift_engine.sv
//==============================================================================
// Module      : tb_spi_shift_engine
// Description : Scoreboard bench for spi_shift_engine with a behavioural SPI
//               slave and transfer-level reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_spi_shift_engine;

    localparam int DATA_W = 32;
    localparam int DIV_W  = 8;
    localparam int LEN_W  = 6;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  len = '0;
    logic [DATA_W-1:0] tx_data = '0;
    logic              cpol = 1'b0;
    logic              cpha = 1'b0;
    logic              lsb_first = 1'b0;
    logic [DIV_W-1:0]  clk_div = '0;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rx_data;
    logic              sck;
    logic              mosi;
    logic              miso;
    logic              cs_n;

    spi_shift_engine #(
        .DATA_W (DATA_W),
        .DIV_W  (DIV_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .len       (len),
        .tx_data   (tx_data),
        .cpol      (cpol),
        .cpha      (cpha),
        .lsb_first (lsb_first),
        .clk_div   (clk_div),
        .busy      (busy),
        .done      (done),
        .rx_data   (rx_data),
        .sck       (sck),
        .mosi      (mosi),
        .miso      (miso),
        .cs_n      (cs_n)
    );

    typedef struct {
        logic [31:0] rx;
        logic [31:0] txw;
        int          len;
        bit          lsb;
        longint      done_cyc;
    } exp_t;

    exp_t   sb[$];
    longint cyc = 0;
    int     checks = 0;
    int     passes = 0;

    bit          s_cpha = 1'b0;
    bit          s_lsb  = 1'b0;
    bit          s_loop = 1'b0;
    int          s_len  = 32;
    logic [31:0] s_word = '0;
    int          edges  = 0;
    bit          prev_sck = 1'b0;
    bit          prev_cs_low = 1'b0;
    bit          mbits[$];

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Slave presents bit i after cs_n falls (cpha=0) or after leading edge i (cpha=1)
    function automatic logic slave_bit(input int e, input bit ch, input int l,
                                       input bit lsb, input logic [31:0] w);
        int idx;
        idx = ch ? ((e == 0) ? 0 : (e - 1) / 2) : e / 2;
        if (idx >= l) return 1'b0;
        return lsb ? w[idx] : w[l-1-idx];
    endfunction

    assign miso = s_loop ? mosi : slave_bit(edges, s_cpha, s_len, s_lsb, s_word);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: counts sck edges inside a frame, captures mosi at slave sample points
    initial forever begin
        @(negedge clk);
        if (!reset_n) begin
            edges = 0;
            mbits.delete();
            prev_cs_low = 1'b0;
            prev_sck = sck;
        end else begin
            if (!cs_n && prev_cs_low && (sck !== prev_sck)) begin
                edges++;
                if ((!s_cpha && (edges % 2 == 1)) || (s_cpha && (edges % 2 == 0)))
                    mbits.push_back(mosi);
            end
            if (done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 64'd1, 64'd0);
                end else begin
                    exp_t        e;
                    logic [31:0] got;
                    e = sb.pop_front();
                    got = '0;
                    for (int i = 0; i < mbits.size() && i < e.len; i++) begin
                        if (e.lsb) got[i] = mbits[i];
                        else       got[e.len-1-i] = mbits[i];
                    end
                    chk("rx_data", 64'(rx_data), 64'(e.rx));
                    chk("mosi_word", 64'(got), 64'(e.txw));
                    chk("sck_edges", 64'(edges), 64'(2 * e.len));
                    chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
                    chk("cs_n_at_done", 64'(cs_n), 64'd1);
                end
            end
            if (cs_n) begin
                edges = 0;
                mbits.delete();
            end
            prev_sck = sck;
            prev_cs_low = !cs_n;
        end
    end

    task automatic issue(input int l, input logic [31:0] tx, input bit cp, input bit ch,
                         input bit lsb, input int div, input logic [31:0] word,
                         input bit loop, input bit hold);
        int          n;
        int          el;
        logic [31:0] mask;
        exp_t        e;
        n = 0;
        while (busy === 1'b1) begin
            @(negedge clk);
            n++;
            if (n > 20000) begin
                chk("issue_timeout", 64'd1, 64'd0);
                return;
            end
        end
        el   = ((l == 0) || (l > 32)) ? 32 : l;
        mask = (el == 32) ? 32'hFFFF_FFFF : ((32'd1 << el) - 32'd1);
        len = LEN_W'(l);
        tx_data = tx;
        cpol = cp;
        cpha = ch;
        lsb_first = lsb;
        clk_div = DIV_W'(div);
        s_cpha = ch;
        s_lsb  = lsb;
        s_len  = el;
        s_word = word;
        s_loop = loop;
        e.rx  = (loop ? tx : word) & mask;
        e.txw = tx & mask;
        e.len = el;
        e.lsb = lsb;
        e.done_cyc = cyc + 1 + longint'((2 * el + 2) * (div + 1));
        sb.push_back(e);
        start = 1'b1;
        @(negedge clk);
        chk("busy_after_start", 64'(busy), 64'd1);
        if (!hold) start = 1'b0;
        // Post-acceptance input changes must not disturb the transfer
        tx_data = $urandom;
        len = LEN_W'($urandom);
        cpha = 1'($urandom);
        lsb_first = 1'($urandom);
        clk_div = DIV_W'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            n++;
            if (n > 20000) begin
                chk("drain_timeout", 64'd0, 64'd1);
                sb.delete();
                return;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_rx_data", 64'(rx_data), 64'd0);
        chk("reset_sck", 64'(sck), 64'd0);
        chk("reset_mosi", 64'(mosi), 64'd0);
        chk("reset_cs_n", 64'(cs_n), 64'd1);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Mode 0, 8-bit loopback, MSB first
        issue(8, 32'hA5, 0, 0, 0, 1, 32'h0, 1, 0);
        wait_idle();

        // Mode 3, 32-bit LSB first against a slave word
        cpol = 1'b1;
        repeat (2) @(negedge clk);
        chk("sck_idle_high_before", 64'(sck), 64'd1);
        issue(32, 32'hDEADBEEF, 1, 1, 1, 0, 32'h12345678, 0, 0);
        wait_idle();
        chk("sck_idle_high_after", 64'(sck), 64'd1);
        cpol = 1'b0;
        repeat (2) @(negedge clk);

        // Length clamp
        issue(0, 32'h0F0F_1234, 0, 0, 0, 0, 32'hCAFE_F00D, 0, 0);
        wait_idle();
        issue(40, 32'h8000_0001, 0, 1, 1, 1, 32'h5A5A_A5A5, 0, 0);
        wait_idle();

        // Back-to-back with start held through the first transfer
        issue(6, 32'h2D, 0, 1, 0, 1, 32'h13, 0, 1);
        n = 0;
        while (busy === 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_done_pulse", 64'(done), 64'd1);
        chk("b2b_cs_high", 64'(cs_n), 64'd1);
        issue(5, 32'h1B, 1, 0, 1, 0, 32'h0A, 1, 0);
        chk("b2b_cs_gap", 64'(cs_n), 64'd0);
        wait_idle();

        // Reset in the middle of a mode 1 transfer
        issue(16, 32'hBEEF, 0, 1, 0, 2, 32'h7E81, 0, 0);
        n = 0;
        while (edges < 5 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        #2 reset_n = 1'b0;
        #1;
        chk("abort_cs_n", 64'(cs_n), 64'd1);
        chk("abort_sck", 64'(sck), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_rx_data", 64'(rx_data), 64'd0);
        sb.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        issue(12, 32'hABC, 0, 1, 0, 1, 32'h5C3, 0, 0);
        wait_idle();

        // Mode 2, single bit
        issue(1, 32'h1, 1, 0, 0, 2, 32'h1, 0, 0);
        wait_idle();
        cpol = 1'b0;

        for (int t = 0; t < 16; t++) begin
            issue(int'($urandom_range(0, 40)), $urandom, 1'($urandom), 1'($urandom),
                  1'($urandom), int'($urandom_range(0, 3)), $urandom, 1'($urandom), 0);
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        wait_idle();
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
